// File: rtl/instr_sequencer_fsm.sv
// ---------------------------------------------------------------------------
// instr_sequencer_fsm
// Moore control FSM for the Simple RISC Machine datapath, with branch support.
// Each instruction is fetched into the IR and the PC is incremented. The FSM
// then dispatches on opcode/op/cond and runs one microstep per cycle until
// HALT. Every output is a registered decode of the state that is being
// entered, so the outputs always match the current state register.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   opcode/op/cond        instruction fields from the IR decoder
//   Z, N, V               status flags, sampled in DEC for branches
//   nsel                  one-hot register field select (001 Rm, 010 Rd, 100 Rn)
//   vsel                  write-back source (00 C, 01 sximm8, 10 PC, 11 mdata)
//   write                 register-file write enable
//   loada/loadb/loadc     A/B/C pipeline register loads
//   loads                 status register load
//   asel, bsel            ALU operand selects (A forced to 0 / B = sximm5)
//   load_ir               IR load
//   load_pc, reset_pc     PC load and PC-to-zero select
//   pc_sel                PC next source (00 PC+1, 01 PC+sximm8, 10 C)
//   addr_sel, load_addr   memory address source and data-address reg load
//   mem_cmd               MNONE / MREAD / MWRITE
//   halted                high in HALT
// ---------------------------------------------------------------------------
module instr_sequencer_fsm #(
    parameter int         MEM_WAIT = 1,
    parameter logic [1:0] MNONE    = 2'b00,
    parameter logic [1:0] MREAD    = 2'b01,
    parameter logic [1:0] MWRITE   = 2'b10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic [1:0] pc_sel,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    // EXEC comes in flavours so that every strobe is a function of state only:
    // EXEC plain ALU, EXEC_S also loads status (CMP), EXEC_I uses sximm5
    // (LDR/STR address), PASS forces A to 0 (MOV Rd,Rm / MVN / STR data / BX).
    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GETA, S_GETB,
        S_EXEC, S_EXEC_S, S_EXEC_I, S_PASS, S_WRD, S_LADR, S_MRD, S_WMEM,
        S_GETD, S_MWR, S_BRL, S_LNK, S_BRC, S_HALT
    } state_t;

    typedef struct packed {
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic [1:0] pc_sel;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

    localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT);

    state_t     state;
    state_t     state_next;
    logic [1:0] wait_cnt;
    ctrl_t      ctrl;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c         = '0;
        c.mem_cmd = MNONE;
        case (s)
            S_RST:    begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
            S_IF1:    begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; end
            S_IF2:    begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; c.load_ir = 1'b1; end
            S_UPC:    begin c.load_pc = 1'b1; c.pc_sel = 2'b00; end
            S_WIMM:   begin c.nsel = 3'b100; c.vsel = 2'b01; c.write = 1'b1; end
            S_GETA:   begin c.nsel = 3'b100; c.loada = 1'b1; end
            S_GETB:   begin c.nsel = 3'b001; c.loadb = 1'b1; end
            S_EXEC:   c.loadc = 1'b1;
            S_EXEC_S: begin c.loadc = 1'b1; c.loads = 1'b1; end
            S_EXEC_I: begin c.loadc = 1'b1; c.bsel = 1'b1; end
            S_PASS:   begin c.loadc = 1'b1; c.asel = 1'b1; end
            S_WRD:    begin c.nsel = 3'b010; c.vsel = 2'b00; c.write = 1'b1; end
            S_LADR:   c.load_addr = 1'b1;
            S_MRD:    begin c.addr_sel = 1'b0; c.mem_cmd = MREAD; end
            S_WMEM:   begin c.nsel = 3'b010; c.vsel = 2'b11; c.write = 1'b1; end
            S_GETD:   begin c.nsel = 3'b010; c.loadb = 1'b1; end
            S_MWR:    begin c.addr_sel = 1'b0; c.mem_cmd = MWRITE; end
            S_BRL:    begin c.load_pc = 1'b1; c.pc_sel = 2'b01; end
            // Rn is 3'b111 for BL/BLX, so nsel=Rn addresses the link register R7.
            S_LNK:    begin c.nsel = 3'b100; c.vsel = 2'b10; c.write = 1'b1; end
            S_BRC:    begin c.load_pc = 1'b1; c.pc_sel = 2'b10; end
            S_HALT:   c.halted = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

    function automatic logic branch_taken(input logic [2:0] cd, input logic z,
                                          input logic n, input logic v);
        case (cd)
            3'b000:  return 1'b1;
            3'b001:  return z;
            3'b010:  return !z;
            3'b011:  return n ^ v;
            3'b100:  return (n ^ v) | z;
            default: return 1'b0;
        endcase
    endfunction

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_RST:  state_next = S_IF1;
            S_IF1:  state_next = (wait_cnt == WAIT_LAST) ? S_IF2 : S_IF1;
            S_IF2:  state_next = S_UPC;
            S_UPC:  state_next = S_DEC;
            S_DEC: begin
                case (opcode)
                    3'b110:  state_next = (op == 2'b10) ? S_WIMM :
                                          (op == 2'b00) ? S_GETB : S_HALT;
                    3'b101:  state_next = S_GETA;
                    3'b011,
                    3'b100:  state_next = (op == 2'b00) ? S_GETA : S_HALT;
                    3'b001:  state_next = branch_taken(cond, Z, N, V) ? S_BRL : S_IF1;
                    3'b010: begin
                        case (op)
                            2'b11,
                            2'b10:   state_next = S_LNK;
                            2'b00:   state_next = S_GETD;
                            default: state_next = S_HALT;
                        endcase
                    end
                    default: state_next = S_HALT;
                endcase
            end
            S_WIMM: state_next = S_IF1;
            S_GETA: state_next = (opcode == 3'b101) ? S_GETB : S_EXEC_I;
            S_GETB: begin
                if (opcode == 3'b110 || op == 2'b11) state_next = S_PASS;
                else if (op == 2'b01)                state_next = S_EXEC_S;
                else                                 state_next = S_EXEC;
            end
            S_EXEC:   state_next = S_WRD;
            S_EXEC_S: state_next = S_IF1;
            S_EXEC_I: state_next = S_LADR;
            S_PASS: begin
                case (opcode)
                    3'b100:  state_next = S_MWR;
                    3'b010:  state_next = S_BRC;
                    default: state_next = S_WRD;
                endcase
            end
            S_WRD:  state_next = S_IF1;
            S_LADR: state_next = (opcode == 3'b011) ? S_MRD : S_GETD;
            S_MRD:  state_next = (wait_cnt == WAIT_LAST) ? S_WMEM : S_MRD;
            S_WMEM: state_next = S_IF1;
            S_GETD: state_next = S_PASS;
            S_MWR:  state_next = S_IF1;
            S_LNK:  state_next = (op == 2'b11) ? S_BRL : S_GETD;
            S_BRL:  state_next = S_IF1;
            S_BRC:  state_next = S_IF1;
            S_HALT: state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; outputs are
    // registered from the decode of state_next so they line up with state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_RST;
            wait_cnt <= '0;
            ctrl     <= decode(S_RST);
        end else begin
            state <= state_next;
            ctrl  <= decode(state_next);
            // Counts cycles spent in a memory-read wait state; clears on any exit.
            if ((state == S_IF1 || state == S_MRD) && state_next == state)
                wait_cnt <= wait_cnt + 2'd1;
            else
                wait_cnt <= '0;
        end
    end

    assign nsel      = ctrl.nsel;
    assign vsel      = ctrl.vsel;
    assign write     = ctrl.write;
    assign loada     = ctrl.loada;
    assign loadb     = ctrl.loadb;
    assign loadc     = ctrl.loadc;
    assign loads     = ctrl.loads;
    assign asel      = ctrl.asel;
    assign bsel      = ctrl.bsel;
    assign load_ir   = ctrl.load_ir;
    assign load_pc   = ctrl.load_pc;
    assign reset_pc  = ctrl.reset_pc;
    assign pc_sel    = ctrl.pc_sel;
    assign addr_sel  = ctrl.addr_sel;
    assign load_addr = ctrl.load_addr;
    assign mem_cmd   = ctrl.mem_cmd;
    assign halted    = ctrl.halted;

endmodule
